// File: rtl/chan_mux_scan_if.sv
// rtl/chan_mux_scan_if.sv - channel/consumer bus bundle for chan_mux_scan
// Optional parity signals are present when CHAN_MUX_PARITY_EN is defined.
interface chan_mux_scan_if #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
);
  logic [NUM_CH*DATA_W-1:0] din;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_ready;
  logic                     mode;
  logic [SEL_W-1:0]         sel_in;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_sel;
  logic                     out_valid;
  logic                     out_ready;
  logic                     sel_err;
  logic                     err_clr;
`ifdef CHAN_MUX_PARITY_EN
  logic [NUM_CH-1:0]        ch_par;
  logic                     out_par_err;

  modport master (
    output din, ch_valid, mode, sel_in, out_ready, err_clr, ch_par,
    input  ch_ready, out_data, out_sel, out_valid, sel_err, out_par_err
  );
  modport slave (
    input  din, ch_valid, mode, sel_in, out_ready, err_clr, ch_par,
    output ch_ready, out_data, out_sel, out_valid, sel_err, out_par_err
  );
`else
  modport master (
    output din, ch_valid, mode, sel_in, out_ready, err_clr,
    input  ch_ready, out_data, out_sel, out_valid, sel_err
  );
  modport slave (
    input  din, ch_valid, mode, sel_in, out_ready, err_clr,
    output ch_ready, out_data, out_sel, out_valid, sel_err
  );
`endif
endinterface

// File: rtl/chan_mux_scan.sv
// rtl/chan_mux_scan.sv - N-channel registered mux with manual or round-robin selection
// Optional per-channel parity check enabled by CHAN_MUX_PARITY_EN.
module chan_mux_scan #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input logic            clk,
  input logic            rst_n,
  chan_mux_scan_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state, state_n;
  logic [SEL_W-1:0]   rr_ptr;
  logic               mode_q;
  logic [SEL_W-1:0]   start_ptr;
  logic               scan_entry;
  logic [SEL_W-1:0]   grant;
  logic               grant_ok;
  logic               sel_bad;
  logic               can_load;
  logic               load;
  logic [NUM_CH-1:0]  ready_vec;
  logic [DATA_W-1:0]  sel_data;
  int                 best_off;
  int                 off;

  // A fresh entry into scan mode searches from channel 0 in that same cycle.
  assign scan_entry = bus.mode && !mode_q;
  assign start_ptr  = scan_entry ? '0 : rr_ptr;
  assign can_load   = (state == EMPTY) || bus.out_ready;
  assign load       = can_load && grant_ok;
  assign bus.ch_ready  = ready_vec;
  assign bus.out_valid = (state == FULL);

  // Grant selection: manual index, or nearest valid channel at/after start_ptr.
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    sel_bad  = 1'b0;
    best_off = NUM_CH;
    off      = 0;
    if (!bus.mode) begin
      if (int'(bus.sel_in) >= NUM_CH) begin
        sel_bad = 1'b1;
      end else begin
        grant = bus.sel_in;
        for (int i = 0; i < NUM_CH; i++) begin
          if (i == int'(bus.sel_in)) grant_ok = bus.ch_valid[i];
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        off = i - int'(start_ptr);
        if (off < 0) off = off + NUM_CH;
        if (bus.ch_valid[i] && (off < best_off)) begin
          best_off = off;
          grant    = SEL_W'(i);
          grant_ok = 1'b1;
        end
      end
    end
  end

  // Per-channel accept strobe and data of the granted channel.
  always_comb begin
    ready_vec = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i == int'(grant)) begin
        ready_vec[i] = load;
        sel_data     = bus.din[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output stage next state: load fills, consumer accept with no load drains.
  always_comb begin
    state_n = state;
    case (state)
      EMPTY:   if (load) state_n = FULL;
      FULL:    if (bus.out_ready && !load) state_n = EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  // State register, output beat, scan pointer and mode history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      bus.out_data <= '0;
      bus.out_sel  <= '0;
      rr_ptr       <= '0;
      mode_q       <= 1'b0;
    end else begin
      state  <= state_n;
      mode_q <= bus.mode;
      if (load) begin
        bus.out_data <= sel_data;
        bus.out_sel  <= grant;
      end
      if (load && bus.mode) begin
        rr_ptr <= (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
      end else if (scan_entry) begin
        rr_ptr <= '0;
      end
    end
  end

  // Sticky bad-select flag; a new error outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sel_err <= 1'b0;
    end else if (sel_bad) begin
      bus.sel_err <= 1'b1;
    end else if (bus.err_clr) begin
      bus.sel_err <= 1'b0;
    end
  end

`ifdef CHAN_MUX_PARITY_EN
  logic sel_par;

  // Parity bit of the granted channel.
  always_comb begin
    sel_par = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i == int'(grant)) sel_par = bus.ch_par[i];
    end
  end

  // Parity error travels and holds with the loaded beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_par_err <= 1'b0;
    end else if (load) begin
      bus.out_par_err <= ^{sel_data, sel_par};
    end
  end
`endif

endmodule

// File: tb/tb_chan_mux_scan.sv
// tb/tb_chan_mux_scan.sv - self-checking bench for chan_mux_scan
module tb_chan_mux_scan;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  chan_mux_scan_if #(.NUM_CH(8), .DATA_W(8)) b8 ();
  chan_mux_scan_if #(.NUM_CH(6), .DATA_W(8)) b6 ();

  chan_mux_scan #(.NUM_CH(8), .DATA_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  chan_mux_scan #(.NUM_CH(6), .DATA_W(8)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for the 8-channel instance: the beat the consumer should
  // see, where the next scan search begins, and the mode seen last cycle.
  bit       m_valid;
  int       m_data;
  int       m_sel;
  int       m_rr;
  bit       m_mode_prev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_sel = 0; m_rr = 0; m_mode_prev = 0;
  endtask

  // Which channel the spec says gets accepted this cycle, if any.
  task automatic predict(output bit ld, output int g);
    int start;
    ld = 0;
    g  = 0;
    if (m_valid && !b8.out_ready) return;
    if (!b8.mode) begin
      if (b8.ch_valid[b8.sel_in]) begin ld = 1; g = int'(b8.sel_in); end
    end else begin
      start = m_mode_prev ? m_rr : 0;
      for (int k = 0; k < 8; k++) begin
        if (!ld && b8.ch_valid[(start + k) % 8]) begin ld = 1; g = (start + k) % 8; end
      end
    end
  endtask

  // One clock cycle on the 8-channel instance with full model comparison.
  task automatic cyc8(input string tag);
    bit            ld;
    int            g;
    logic [7:0]    exp_rdy;
    logic [63:0]   d;
    #1;
    predict(ld, g);
    exp_rdy = 8'h00;
    if (ld) exp_rdy[g] = 1'b1;
    chk({tag, "_ready"}, 64'(b8.ch_ready), 64'(exp_rdy));
    d = 64'(b8.din);
    @(posedge clk);
    if (ld) begin
      m_valid = 1;
      m_data  = int'(d >> (g * 8)) & 8'hFF;
      m_sel   = g;
      if (b8.mode) m_rr = (g + 1) % 8;
    end else begin
      if (b8.out_ready) m_valid = 0;
      if (b8.mode && !m_mode_prev) m_rr = 0;
    end
    m_mode_prev = b8.mode;
    #1;
    chk({tag, "_valid"}, 64'(b8.out_valid), 64'(m_valid));
    if (m_valid) begin
      chk({tag, "_data"}, 64'(b8.out_data), 64'(m_data));
      chk({tag, "_sel"}, 64'(b8.out_sel), 64'(m_sel));
    end
  endtask

  task automatic set_ramp_data();
    for (int i = 0; i < 8; i++) b8.din[i*8 +: 8] = 8'(8'h10 + i);
  endtask

  initial begin
    int exp_seq [6] = '{0, 2, 5, 7, 0, 2};
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    b8.din = '0; b8.ch_valid = '0; b8.mode = 0; b8.sel_in = '0; b8.out_ready = 0; b8.err_clr = 0;
    b6.din = '0; b6.ch_valid = '0; b6.mode = 0; b6.sel_in = '0; b6.out_ready = 1; b6.err_clr = 0;
    model_reset();

    // Reset state
    #12;
    chk("rst_valid", 64'(b8.out_valid), 64'd0);
    chk("rst_data", 64'(b8.out_data), 64'd0);
    chk("rst_sel", 64'(b8.out_sel), 64'd0);
    chk("rst_err", 64'(b8.sel_err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Manual sweep
    set_ramp_data();
    b8.ch_valid = 8'hFF; b8.out_ready = 1;
    for (int s = 0; s < 8; s++) begin
      b8.sel_in = 3'(s);
      #1;
      chk("sweep_onehot", 64'(b8.ch_ready), 64'(8'h01 << s));
      cyc8("sweep");
      chk("sweep_val", 64'(b8.out_data), 64'(8'h10 + s));
    end

    // Backpressure then back-to-back load
    b8.sel_in = 3'd3;
    cyc8("bp_load");
    b8.out_ready = 0;
    for (int c = 0; c < 4; c++) begin
      cyc8("bp_hold");
      chk("bp_data", 64'(b8.out_data), 64'h13);
      chk("bp_rdy0", 64'(b8.ch_ready), 64'd0);
    end
    b8.out_ready = 1; b8.sel_in = 3'd4;
    cyc8("bp_b2b");
    chk("b2b_data", 64'(b8.out_data), 64'h14);
    chk("b2b_valid", 64'(b8.out_valid), 64'd1);

    // Round-robin fairness with wrap, then drain
    b8.mode = 1; b8.ch_valid = 8'b1010_0101;
    for (int c = 0; c < 6; c++) begin
      cyc8("rr");
      chk("rr_seq", 64'(b8.out_sel), 64'(exp_seq[c]));
    end
    b8.ch_valid = 8'h00;
    cyc8("rr_drain");
    chk("rr_drained", 64'(b8.out_valid), 64'd0);

    // Scan re-entry restarts at channel 0
    b8.ch_valid = 8'h20;
    cyc8("ent_g5");
    b8.mode = 0; b8.sel_in = 3'd1; b8.ch_valid = 8'h00;
    cyc8("ent_man");
    b8.mode = 1; b8.ch_valid = 8'hFF;
    cyc8("ent_scan");
    chk("ent_first", 64'(b8.out_sel), 64'd0);
    cyc8("ent_next");
    chk("ent_second", 64'(b8.out_sel), 64'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      b8.din       = {$urandom, $urandom};
      b8.ch_valid  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) b8.mode = ~b8.mode;
      b8.sel_in    = 3'($urandom_range(0, 7));
      b8.out_ready = ($urandom_range(0, 3) != 0);
      cyc8("rand");
    end

    // Invalid select on the 6-channel instance
    b6.ch_valid = 6'h3F; b6.sel_in = 3'd7;
    #1;
    chk("bad_rdy", 64'(b6.ch_ready), 64'd0);
    @(posedge clk); #1;
    chk("bad_err_set", 64'(b6.sel_err), 64'd1);
    b6.sel_in = 3'd2;
    @(posedge clk); #1;
    chk("bad_err_sticky", 64'(b6.sel_err), 64'd1);
    chk("bad_recover_sel", 64'(b6.out_sel), 64'd2);
    b6.sel_in = 3'd6; b6.err_clr = 1;
    @(posedge clk); #1;
    chk("bad_set_wins", 64'(b6.sel_err), 64'd1);
    b6.sel_in = 3'd2;
    @(posedge clk); #1;
    chk("bad_cleared", 64'(b6.sel_err), 64'd0);
    b6.err_clr = 0;

    // Async reset while a beat is held
    b8.mode = 0; b8.sel_in = 3'd5; b8.ch_valid = 8'hFF; b8.out_ready = 0;
    set_ramp_data();
    cyc8("pre_rst");
    cyc8("pre_rst_hold");
    chk("pre_rst_valid", 64'(b8.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(b8.out_valid), 64'd0);
    chk("arst_data", 64'(b8.out_data), 64'd0);
    chk("arst_sel", 64'(b8.out_sel), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    b8.mode = 1; b8.ch_valid = 8'hFF; b8.out_ready = 1;
    cyc8("post_rst");
    chk("post_rst_sel", 64'(b8.out_sel), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
